jet_motion: RTL and testbench



---
 rtl/jet_motion.sv | 157 +++++++++++++++
 tb/tb_jet_motion.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/jet_motion.sv
// Per-frame jet motion: picks up keycode at each vsync edge, steers heading/speed,
// then advances the jet centre with wrap-around at the screen edges.
module jet_motion #(
    parameter int X_CENTER  = 320,
    parameter int Y_CENTER  = 240,
    parameter int X_MAX     = 639,
    parameter int Y_MAX     = 479,
    parameter int JET_SIZE  = 4,
    parameter int MAX_SPEED = 4,
    parameter int TURN_DIV  = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    output logic [9:0] JetX,
    output logic [9:0] JetY,
    output logic [9:0] Jet_size,
    output logic [2:0] heading,
    output logic       update_done
);

    localparam int TW = (TURN_DIV > 1) ? $clog2(TURN_DIV) : 1;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_D = 8'h07;
    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic signed [11:0] XM   = 12'(X_MAX);
    localparam logic signed [11:0] YM   = 12'(Y_MAX);
    localparam logic signed [11:0] XMOD = 12'(X_MAX + 1);
    localparam logic signed [11:0] YMOD = 12'(Y_MAX + 1);

    typedef enum logic [1:0] {S_WAIT, S_STEER, S_MOVE} state_t;

    state_t          state_reg, state_next;
    logic            sync1_reg, sync2_reg, hist_reg;
    logic            frame_tick;
    logic [7:0]      key_q_reg;
    logic [3:0]      speed_reg, speed_next;
    logic [TW-1:0]   turn_cnt_reg, turn_cnt_next;
    logic [2:0]      heading_next;
    logic            latch_key, steer_en, move_en;
    logic            dx_pos, dx_neg, dy_pos, dy_neg;
    logic signed [11:0] step, nx, ny, nx_w, ny_w;

    assign Jet_size   = 10'(JET_SIZE);
    assign frame_tick = sync2_reg & ~hist_reg;

    // Synchroniser and history reset high so a frame_clk already high at release is not an edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            hist_reg  <= 1'b1;
        end else begin
            sync1_reg <= frame_clk;
            sync2_reg <= sync1_reg;
            hist_reg  <= sync2_reg;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_reg <= S_WAIT;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_WAIT:  if (frame_tick) state_next = S_STEER;
            S_STEER: state_next = S_MOVE;
            S_MOVE:  state_next = S_WAIT;
            default: state_next = S_WAIT;
        endcase
    end

    always_comb begin
        latch_key = (state_reg == S_WAIT) && frame_tick;
        steer_en  = (state_reg == S_STEER);
        move_en   = (state_reg == S_MOVE);
    end

    // Heading, speed and turn pacing from the latched key.
    always_comb begin
        heading_next  = heading;
        speed_next    = speed_reg;
        turn_cnt_next = '0;
        if (key_q_reg == KEY_A || key_q_reg == KEY_D) begin
            if (turn_cnt_reg == '0)
                heading_next = (key_q_reg == KEY_D) ? heading + 3'd1 : heading - 3'd1;
            turn_cnt_next = (turn_cnt_reg == TW'(TURN_DIV - 1)) ? '0 : turn_cnt_reg + 1'b1;
        end else if (key_q_reg == KEY_W) begin
            if (speed_reg < 4'(MAX_SPEED)) speed_next = speed_reg + 4'd1;
        end else if (key_q_reg == KEY_S) begin
            if (speed_reg > 4'd1) speed_next = speed_reg - 4'd1;
        end
    end

    always_comb begin
        dx_pos = 1'b0;
        dx_neg = 1'b0;
        dy_pos = 1'b0;
        dy_neg = 1'b0;
        case (heading)
            3'd0: dy_neg = 1'b1;
            3'd1: begin dx_pos = 1'b1; dy_neg = 1'b1; end
            3'd2: dx_pos = 1'b1;
            3'd3: begin dx_pos = 1'b1; dy_pos = 1'b1; end
            3'd4: dy_pos = 1'b1;
            3'd5: begin dx_neg = 1'b1; dy_pos = 1'b1; end
            3'd6: dx_neg = 1'b1;
            default: begin dx_neg = 1'b1; dy_neg = 1'b1; end
        endcase
    end

    // Speed never exceeds 15, so one modulus correction is enough.
    always_comb begin
        step = signed'({8'd0, speed_reg});
        nx   = signed'({2'b00, JetX});
        ny   = signed'({2'b00, JetY});
        if (dx_pos) nx = nx + step;
        if (dx_neg) nx = nx - step;
        if (dy_pos) ny = ny + step;
        if (dy_neg) ny = ny - step;
        nx_w = nx;
        ny_w = ny;
        if (nx > XM)          nx_w = nx - XMOD;
        else if (nx < 12'sd0) nx_w = nx + XMOD;
        if (ny > YM)          ny_w = ny - YMOD;
        else if (ny < 12'sd0) ny_w = ny + YMOD;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            key_q_reg    <= 8'h00;
            heading      <= 3'd0;
            speed_reg    <= 4'd1;
            turn_cnt_reg <= '0;
            JetX         <= 10'(X_CENTER);
            JetY         <= 10'(Y_CENTER);
            update_done  <= 1'b0;
        end else begin
            update_done <= move_en;
            if (latch_key) key_q_reg <= keycode;
            if (steer_en) begin
                heading      <= heading_next;
                speed_reg    <= speed_next;
                turn_cnt_reg <= turn_cnt_next;
            end
            if (move_en) begin
                JetX <= 10'(nx_w);
                JetY <= 10'(ny_w);
            end
        end
    end

endmodule

// File: tb/tb_jet_motion.sv
// Randomised frame stimulus for jet_motion against a plain-arithmetic motion model,
// with a queue-based scoreboard checked on every update_done pulse.
module tb_jet_motion;

    localparam int TURN_DIV = 4;
    localparam int MAXSPD   = 4;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b1;
    logic [7:0] keycode = 8'h00;
    logic [9:0] JetX, JetY, Jet_size;
    logic [2:0] heading;
    logic       update_done;

    jet_motion dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
        .JetX(JetX), .JetY(JetY), .Jet_size(Jet_size), .heading(heading),
        .update_done(update_done)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct { int x; int y; int h; int c; } exp_t;
    exp_t exp_q[$];
    exp_t ev;

    int n_cmp = 0;
    int n_err = 0;

    int mx, my, mh, ms, mt;
    int DX[8] = '{0, 1, 1, 1, 0, -1, -1, -1};
    int DY[8] = '{-1, -1, 0, 1, 1, 1, 0, -1};

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        mx = 320; my = 240; mh = 0; ms = 1; mt = 0;
    endtask

    task automatic model_frame(input logic [7:0] key);
        if (key == 8'h04 || key == 8'h07) begin
            if (mt == 0) mh = (mh + ((key == 8'h07) ? 1 : 7)) % 8;
            mt = (mt == TURN_DIV - 1) ? 0 : mt + 1;
        end else begin
            mt = 0;
            if (key == 8'h1A && ms < MAXSPD) ms = ms + 1;
            if (key == 8'h16 && ms > 1)      ms = ms - 1;
        end
        mx = ((mx + DX[mh] * ms) % 640 + 640) % 640;
        my = ((my + DY[mh] * ms) % 480 + 480) % 480;
    endtask

    // Monitor: every update_done must match the oldest pending expectation.
    always @(negedge Clk) begin
        if (update_done) begin
            if (exp_q.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                ev = exp_q.pop_front();
                $display("frame done: x=%0d y=%0d heading=%0d cyc=%0d", JetX, JetY, heading, cyc);
                chk("done_cycle", cyc, ev.c);
                chk("jet_x", int'(JetX), ev.x);
                chk("jet_y", int'(JetY), ev.y);
                chk("heading", int'(heading), ev.h);
                chk("jet_size", int'(Jet_size), 4);
            end
        end
    end

    // Rising frame_clk at a negedge makes the pulse land exactly 5 posedges later.
    task automatic do_frame(input logic [7:0] key);
        exp_t e;
        @(negedge Clk);
        keycode   = key;
        frame_clk = 1'b1;
        model_frame(key);
        e.x = mx; e.y = my; e.h = mh; e.c = cyc + 5;
        exp_q.push_back(e);
        repeat (3) @(negedge Clk);
        keycode = 8'($urandom);
        repeat (4) @(negedge Clk);
        chk("done_seen", exp_q.size(), 0);
        exp_q.delete();
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    function automatic logic [7:0] pick_key();
        case ($urandom_range(0, 9))
            0, 1:    return 8'h1A;
            2:       return 8'h16;
            3:       return 8'h04;
            4, 5:    return 8'h07;
            6:       return 8'h00;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        model_reset();
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        chk("rst_x", int'(JetX), 320);
        chk("rst_y", int'(JetY), 240);
        chk("rst_heading", int'(heading), 0);
        chk("rst_size", int'(Jet_size), 4);
        repeat (6) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);

        do_frame(8'h00);
        chk("no_key_y", int'(JetY), 239);

        for (int i = 0; i < 8; i++) do_frame(8'h07);
        chk("turn_rate_heading", int'(heading), 2);

        for (int i = 0; i < 250; i++) do_frame(pick_key());

        // Reset while the position update is in flight.
        @(negedge Clk);
        keycode   = 8'h1A;
        frame_clk = 1'b1;
        repeat (4) @(negedge Clk);
        Reset = 1'b1;
        #1;
        chk("midrst_x", int'(JetX), 320);
        chk("midrst_y", int'(JetY), 240);
        chk("midrst_heading", int'(heading), 0);
        chk("midrst_done", int'(update_done), 0);
        model_reset();
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        repeat (6) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        do_frame(8'h1A);
        chk("post_rst_y", int'(JetY), 238);

        chk("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
